dotclk_pll_sequencer: RTL
=========================

# dotclk_pll_sequencer

Start-up and supervision sequencer for the iCE40 dot-clock PLL that drives the ILI9341 pixel clock. Runs in the 12 MHz reference clock domain. Holds the PLL in reset for a fixed time, waits for and qualifies LOCK, and then asserts `ready` to release the dot-clock domain. It retries on lock timeout, latches a fault after repeated failures and counts lock-loss events.

## Interface
- `RESET_CYCLES`, 16: cycles `pll_resetb` is held low per reset attempt (≥2).
- `LOCK_STABLE`, 1024: consecutive cycles of synchronized lock required before `ready` (≥1).
- `LOCK_TIMEOUT`, 65536: cycles allowed in WAIT_LOCK before the attempt fails (≥2).
- `MAX_RETRIES`, 3: failed attempts before FAULT (1..15).

- `clock_in`  in  1  12 MHz reference clock (also the PLL REFERENCECLK).
- `reset_n`  in  1  asynchronous, active-low reset.
- `locked_in`  in  1  PLL LOCK. Asynchronous to `clock_in` and synchronized internally.
- `retry_req`  in  1  single-cycle request to restart the sequence from any state.
- `pll_resetb`  out  1  drives PLL RESETB. Low means PLL in reset.
- `ready`  out  1  dot clock qualified and stable.
- `fault`  out  1  lock never achieved within MAX_RETRIES attempts.
- `state`  out  3  current state encoding.
- `lock_loss_count`  out  8  lock losses seen in RUN. Saturates at 255.

## Operation
- `locked_in` passes through a 2-flop synchronizer; `lock_s` is the second flop. All outputs are registered.
- Internal registers:
  - `cnt`, shared phase counter, width = clog2 of the largest of RESET_CYCLES, LOCK_STABLE, LOCK_TIMEOUT.
  - `attempts`, 4 bits.
- Values on `reset_n` low:
  - `state` = RESET, `cnt` = 0, `attempts` = 0.
  - `pll_resetb` = 0, `ready` = 0, `fault` = 0, `lock_loss_count` = 0.
  - Synchronizer flops = 0.
- States and encodings:
  - RESET = 0: `pll_resetb` = 0, `cnt` increments. At `cnt` == RESET_CYCLES-1, go to WAIT_LOCK and clear `cnt`.
  - WAIT_LOCK = 1: `pll_resetb` = 1.
    - If `lock_s` is high, go to QUALIFY and clear `cnt`.
    - Else, at `cnt` == LOCK_TIMEOUT-1, increment `attempts`. If the new value equals MAX_RETRIES, go to FAULT; otherwise go to RESET. Clear `cnt` in both cases.
  - QUALIFY = 2:
    - If `lock_s` is low, return to WAIT_LOCK and clear `cnt`. This is not counted as an attempt.
    - At `cnt` == LOCK_STABLE-1 with `lock_s` high, go to RUN and clear `attempts`.
  - RUN = 3: `ready` = 1. If `lock_s` is low, go to RESET, clear `cnt`, and increment `lock_loss_count` (saturating).
  - FAULT = 4: `pll_resetb` = 0 and `fault` = 1. The block stays here until `retry_req`.
- `retry_req` takes priority over every transition, in any state:
  - Next state = RESET; `cnt`, `attempts` and `fault` are cleared.
  - `lock_loss_count` is not incremented, even if lock drops in the same cycle.
- Output equations, registered from the next state:
  - `ready` = (next state == RUN).
  - `fault` = (next state == FAULT).
  - `pll_resetb` = (next state ∈ {WAIT_LOCK, QUALIFY, RUN}).
- `lock_loss_count` is cleared only by `reset_n`.

## Timing
- Sync latency: a change on `locked_in` is visible as `lock_s` after 2 rising edges.
- After `reset_n` deasserts:
  - `pll_resetb` rises on the RESET_CYCLES-th rising edge.
  - The first WAIT_LOCK cycle follows that edge.
- Lock to ready: `lock_s` high in WAIT_LOCK at edge k gives QUALIFY from edge k, and `ready` rises at edge k+LOCK_STABLE if lock holds.
- Lock loss in RUN:
  - `ready` falls and `pll_resetb` falls on the edge after `lock_s` is first seen low. This is at most 3 edges after `locked_in` falls.
  - The count increments on that same edge.
- Timeout: each failed attempt lasts RESET_CYCLES + LOCK_TIMEOUT cycles. FAULT is entered after MAX_RETRIES such attempts.
- `retry_req` takes effect on the next edge. `state` = 0 and `pll_resetb` = 0 in the following cycle.
- `reset_n` asserted mid-operation forces all reset values immediately (asynchronous). This includes `pll_resetb` = 0 and `ready` = 0.

## Test plan
Benches use RESET_CYCLES=4, LOCK_STABLE=8, LOCK_TIMEOUT=32 and MAX_RETRIES=2.
- **Normal bring-up:** release `reset_n`, then drive `locked_in`=1 when `pll_resetb` rises -> `pll_resetb`=1 at edge 4, `state` goes 1→2→3, and `ready`=1 exactly 8 edges after QUALIFY entry. `fault`=0 and `lock_loss_count`=0.
- **Lock glitch in QUALIFY:** hold lock for 5 cycles, drop it for 1, then hold it again -> return to WAIT_LOCK with no attempt counted. `ready` asserts 8 edges after the second QUALIFY entry.
- **Timeout and fault:** keep `locked_in`=0 -> RESET/WAIT_LOCK runs twice (36 cycles each), then `state`=4, `fault`=1 and `pll_resetb`=0 held for 100 cycles. A `retry_req` pulse then gives `state`=0 and `fault`=0 next cycle, with a full sequence following.
- **Lock loss in RUN:** drop `locked_in` in RUN -> `ready`=0 within 3 edges and `lock_loss_count`=1. Repeat 300 times and `lock_loss_count` stays at 255.
- **Simultaneous `retry_req` and lock loss in RUN:** -> `state`=0 next cycle and `lock_loss_count` unchanged.
- **Async reset mid-QUALIFY:** assert `reset_n` low between edges -> `pll_resetb`, `ready` and `state` go to 0 before the next edge. The sequence then restarts from RESET with a 4-cycle hold.

Source files
------------

// File: rtl/dotclk_pll_sequencer.sv
// dotclk_pll_sequencer
// Start-up and supervision sequencer for the dot-clock PLL, running in the
// 12 MHz reference domain. Holds the PLL in reset, waits for LOCK, qualifies
// it for LOCK_STABLE cycles and then raises ready. Retries on lock timeout,
// latches a fault after MAX_RETRIES failed attempts and counts lock losses.
//
// Ports:
//   clock_in        - 12 MHz reference clock
//   reset_n         - asynchronous active-low reset
//   locked_in       - PLL LOCK, asynchronous, synchronized internally
//   retry_req       - single-cycle restart request, highest priority
//   pll_resetb      - PLL RESETB (low holds PLL in reset)
//   ready           - dot clock qualified and stable
//   fault           - lock never achieved within MAX_RETRIES attempts
//   state           - current state encoding
//   lock_loss_count - lock losses seen in RUN, saturating at 255
module dotclk_pll_sequencer #(
    parameter int unsigned RESET_CYCLES = 16,
    parameter int unsigned LOCK_STABLE  = 1024,
    parameter int unsigned LOCK_TIMEOUT = 65536,
    parameter int unsigned MAX_RETRIES  = 3
) (
    input  logic       clock_in,
    input  logic       reset_n,
    input  logic       locked_in,
    input  logic       retry_req,
    output logic       pll_resetb,
    output logic       ready,
    output logic       fault,
    output logic [2:0] state,
    output logic [7:0] lock_loss_count
);

    localparam int unsigned MaxA      = (RESET_CYCLES > LOCK_STABLE) ? RESET_CYCLES : LOCK_STABLE;
    localparam int unsigned MaxCycles = (MaxA > LOCK_TIMEOUT) ? MaxA : LOCK_TIMEOUT;
    localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

    localparam logic [CntW-1:0] ResetLast   = CntW'(RESET_CYCLES - 1);
    localparam logic [CntW-1:0] StableLast  = CntW'(LOCK_STABLE - 1);
    localparam logic [CntW-1:0] TimeoutLast = CntW'(LOCK_TIMEOUT - 1);
    localparam logic [3:0]      MaxAttempts = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        StReset    = 3'd0,
        StWaitLock = 3'd1,
        StQualify  = 3'd2,
        StRun      = 3'd3,
        StFault    = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      attempts_q, attempts_d;
    logic [7:0]      llc_q, llc_d;
    logic            sync1_q, lock_s_q;
    logic            pll_resetb_q, ready_q, fault_q;
    logic [3:0]      attempts_inc;

    assign attempts_inc = attempts_q + 4'd1;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        attempts_d = attempts_q;
        llc_d      = llc_q;
        if (retry_req) begin
            // Restart wins over every transition, including a lock loss in RUN.
            state_d    = StReset;
            cnt_d      = '0;
            attempts_d = '0;
        end else begin
            unique case (state_q)
                StReset: begin
                    if (cnt_q == ResetLast) begin
                        state_d = StWaitLock;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StWaitLock: begin
                    if (lock_s_q) begin
                        state_d = StQualify;
                        cnt_d   = '0;
                    end else if (cnt_q == TimeoutLast) begin
                        attempts_d = attempts_inc;
                        state_d    = (attempts_inc == MaxAttempts) ? StFault : StReset;
                        cnt_d      = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StQualify: begin
                    if (!lock_s_q) begin
                        // A glitch during qualification is not a failed attempt.
                        state_d = StWaitLock;
                        cnt_d   = '0;
                    end else if (cnt_q == StableLast) begin
                        state_d    = StRun;
                        cnt_d      = '0;
                        attempts_d = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StRun: begin
                    if (!lock_s_q) begin
                        state_d = StReset;
                        cnt_d   = '0;
                        if (llc_q != 8'hFF) begin
                            llc_d = llc_q + 8'd1;
                        end
                    end
                end
                StFault: begin
                    state_d = StFault;
                end
                default: begin
                    state_d = StReset;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q      <= 1'b0;
            lock_s_q     <= 1'b0;
            state_q      <= StReset;
            cnt_q        <= '0;
            attempts_q   <= '0;
            llc_q        <= '0;
            pll_resetb_q <= 1'b0;
            ready_q      <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            sync1_q      <= locked_in;
            lock_s_q     <= sync1_q;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            attempts_q   <= attempts_d;
            llc_q        <= llc_d;
            // Outputs are registered from the next state so they align with state.
            pll_resetb_q <= (state_d == StWaitLock) || (state_d == StQualify) ||
                            (state_d == StRun);
            ready_q      <= (state_d == StRun);
            fault_q      <= (state_d == StFault);
        end
    end

    assign pll_resetb      = pll_resetb_q;
    assign ready           = ready_q;
    assign fault           = fault_q;
    assign state           = state_q;
    assign lock_loss_count = llc_q;

endmodule
